// File: rtl/comb_equiv_sweep.sv
// comb_equiv_sweep: self-running exhaustive equivalence checker.
// It sweeps every WIDTH-bit input vector onto vec_out. For each vector it
// holds SETTLE extra cycles, then compares every implementation output
// y_in[i] against the reference channel y_in[0]. It accumulates the mismatch
// count, the first failing vector and a sticky per-channel fail mask.
// Optional macro COMB_EQUIV_XCHECK_EN (simulation only): compare with !==, so
// an X/Z on one side of a comparison counts as a mismatch.
module comb_equiv_sweep #(
  parameter int WIDTH  = 4,
  parameter int NIMPL  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] vec_out,
  input  logic [NIMPL-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   mismatch_cnt,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic             fail_valid,
  output logic [NIMPL-1:0] fail_mask
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  state_t           state;
  logic [7:0]       wait_cnt;
  logic [NIMPL-1:0] chan_diff;
  logic             any_diff;
  logic [WIDTH:0]   cnt_next;

  // Per-channel disagreement with the reference channel; bit 0 is never set.
  always_comb begin
    chan_diff = '0;
    for (int unsigned i = 1; i < NIMPL; i++) begin
`ifdef COMB_EQUIV_XCHECK_EN
      if (y_in[i] !== y_in[0]) chan_diff[i] = 1'b1;
`else
      if (y_in[i] != y_in[0]) chan_diff[i] = 1'b1;
`endif
    end
  end

  // Mismatch flag and the count including the current compare.
  always_comb begin
    any_diff = |chan_diff;
    cnt_next = mismatch_cnt + (WIDTH+1)'(any_diff);
  end

  // Sweep controller with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      vec_out        <= '0;
      wait_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_vec <= '0;
      fail_valid     <= 1'b0;
      fail_mask      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state          <= S_RUN;
            vec_out        <= '0;
            wait_cnt       <= '0;
            busy           <= 1'b1;
            mismatch_cnt   <= '0;
            fail_mask      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
            pass           <= 1'b0;
          end
        end
        S_RUN: begin
          if (wait_cnt != SETTLE_CNT) begin
            wait_cnt <= wait_cnt + 8'd1;
          end else begin
            wait_cnt <= '0;
            if (any_diff) begin
              mismatch_cnt <= cnt_next;
              fail_mask    <= fail_mask | chan_diff;
              if (!fail_valid) begin
                first_fail_vec <= vec_out;
                fail_valid     <= 1'b1;
              end
            end
            // pass uses cnt_next so the final vector's compare is included.
            if (vec_out == '1) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (cnt_next == '0);
            end else begin
              vec_out <= vec_out + WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comb_equiv_sweep.sv
// Bench for comb_equiv_sweep: two instances (SETTLE=1 and SETTLE=0) drive
// parity "implementations" with per-vector fault masks. A timeline model
// predicts every output on every cycle.
module tb_comb_equiv_sweep;

  localparam int W  = 4;
  localparam int NV = 1 << W;
  localparam int NI = 4;

  int st [2] = '{1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;

  logic [W-1:0]  vec0, vec1, ffv0, ffv1;
  logic [NI-1:0] y0, y1, fm0, fm1;
  logic          busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;
  logic [W:0]    cnt0, cnt1;

  // Channel i outputs parity of the vector, inverted where fault bit i is set.
  logic [NI-1:0] fault [2][NV];
  assign y0 = {NI{^vec0}} ^ fault[0][vec0];
  assign y1 = {NI{^vec1}} ^ fault[1][vec1];

  comb_equiv_sweep #(.WIDTH(W), .NIMPL(NI), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec_out(vec0), .y_in(y0),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(cnt0),
    .first_fail_vec(ffv0), .fail_valid(fv0), .fail_mask(fm0));

  comb_equiv_sweep #(.WIDTH(W), .NIMPL(NI), .SETTLE(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec_out(vec1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(cnt1),
    .first_fail_vec(ffv1), .fail_valid(fv1), .fail_mask(fm1));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Timeline model: e = edges since the accepted start edge; ns = vectors sampled so far.
  bit            act   [2];
  int            e     [2];
  int            ns    [2];
  logic [W-1:0]  hold  [2];
  bit            mpass [2];
  logic [NI-1:0] mf    [2][NV];

  task automatic stats(input int d, input int upto, output int cnt,
                       output logic [NI-1:0] mask, output bit valid, output int first);
    cnt = 0; mask = '0; valid = 1'b0; first = 0;
    for (int v = 0; v < upto; v++) begin
      logic [NI-1:0] df;
      df = mf[d][v] ^ {NI{mf[d][v][0]}};
      if (df != '0) begin
        cnt++;
        mask |= df;
        if (!valid) begin valid = 1'b1; first = v; end
      end
    end
  endtask

  always @(posedge clk) begin
    int per, cn, fs;
    logic [NI-1:0] mk;
    bit vl, s;
    cyc++;
    chk_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      per = NV * (st[d] + 1);
      s = (d == 0) ? start0 : start1;
      if (rst) begin
        act[d] = 1'b0; ns[d] = 0; hold[d] = '0; mpass[d] = 1'b0;
      end else if (act[d]) begin
        e[d]++;
        if (e[d] < per) ns[d] = e[d] / (st[d] + 1);
        else if (e[d] == per) begin
          ns[d] = NV; hold[d] = '1;
          stats(d, NV, cn, mk, vl, fs);
          mpass[d] = (cn == 0);
        end else act[d] = 1'b0;
      end else if (s) begin
        act[d] = 1'b1; e[d] = 0; ns[d] = 0; mpass[d] = 1'b0; hold[d] = '0;
        for (int v = 0; v < NV; v++) mf[d][v] = fault[d][v];
      end
    end
  end

  task automatic cmp(input int d, input logic [W-1:0] v, input logic b, input logic dn,
                     input logic p, input logic [W:0] c, input logic [W-1:0] ff,
                     input logic fv, input logic [NI-1:0] fm);
    int per, cn, fs;
    bit eb, ed, vl;
    logic [W-1:0] ev;
    logic [NI-1:0] mk;
    per = NV * (st[d] + 1);
    eb = act[d] && (e[d] < per);
    ed = act[d] && (e[d] == per);
    ev = eb ? W'(e[d] / (st[d] + 1)) : hold[d];
    stats(d, ns[d], cn, mk, vl, fs);
    chk($sformatf("d%0d vec_out", d), 32'(v), 32'(ev));
    chk($sformatf("d%0d busy", d), 32'(b), 32'(eb));
    chk($sformatf("d%0d done", d), 32'(dn), 32'(ed));
    chk($sformatf("d%0d pass", d), 32'(p), 32'(mpass[d]));
    chk($sformatf("d%0d mismatch_cnt", d), 32'(c), 32'(cn));
    chk($sformatf("d%0d first_fail_vec", d), 32'(ff), 32'(fs));
    chk($sformatf("d%0d fail_valid", d), 32'(fv), 32'(vl));
    chk($sformatf("d%0d fail_mask", d), 32'(fm), 32'(mk));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, vec0, busy0, done0, pass0, cnt0, ffv0, fv0, fm0);
      cmp(1, vec1, busy1, done1, pass1, cnt1, ffv1, fv1, fm1);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic dn_of(input int d);
    return (d == 0) ? done0 : done1;
  endfunction

  task automatic set_start(input int d, input logic val);
    if (d == 0) start0 = val;
    else start1 = val;
  endtask

  // One sweep; edges = start edge to done-visible edge, -1 on timeout.
  task automatic sweep(input int d, input bit noisy, output int edges);
    int t0;
    edges = -1;
    tick; set_start(d, 1'b1);
    tick; t0 = cyc; set_start(d, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (dn_of(d)) begin edges = cyc - t0; break; end
      tick;
      if (noisy) set_start(d, 1'($urandom_range(0, 1)));
    end
    set_start(d, 1'b0);
  endtask

  task automatic chk_res(input string tag, input int d, input int c, input int ff,
                         input int fv, input int fm, input int p);
    chk({tag, " mismatch_cnt"},   32'((d == 0) ? cnt0 : cnt1), c);
    chk({tag, " first_fail_vec"}, 32'((d == 0) ? ffv0 : ffv1), ff);
    chk({tag, " fail_valid"},     32'((d == 0) ? fv0 : fv1), fv);
    chk({tag, " fail_mask"},      32'((d == 0) ? fm0 : fm1), fm);
    chk({tag, " pass"},           32'((d == 0) ? pass0 : pass1), p);
  endtask

  initial begin
    int ed, t0, ndone, d;
    bit found;
    for (int dd = 0; dd < 2; dd++)
      for (int v = 0; v < NV; v++) fault[dd][v] = '0;
    rst = 1'b1;
    repeat (3) tick;
    chk("reset vec_out", 32'(vec0), 0);
    chk("reset busy", 32'(busy0), 0);
    chk("reset done", 32'(done0), 0);
    chk_res("reset d0", 0, 0, 0, 0, 0, 0);
    chk_res("reset d1", 1, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // All channels agree.
    sweep(0, 1'b0, ed);
    chk("t1 done edge", ed, 32);
    chk_res("t1", 0, 0, 0, 0, 0, 1);

    // Channel 2 wrong only at vector A.
    fault[0][10] = 4'b0100;
    sweep(0, 1'b0, ed);
    chk("t2 done edge", ed, 32);
    chk_res("t2", 0, 1, 'hA, 1, 'b0100, 0);
    fault[0][10] = '0;

    // Channels 1 and 3 wrong at vectors 3 and C.
    fault[0][3] = 4'b1010;
    fault[0][12] = 4'b1010;
    sweep(0, 1'b0, ed);
    chk_res("t3", 0, 2, 3, 1, 'b1010, 0);
    fault[0][3] = '0;
    fault[0][12] = '0;

    // start held high: exactly one done per sweep, re-trigger from IDLE.
    tick; start0 = 1'b1;
    tick; t0 = cyc; ndone = 0;
    for (int i = 0; i < 300; i++) begin
      if (done0) begin
        ndone++;
        if (ndone == 2) break;
      end
      tick;
    end
    start0 = 1'b0;
    chk("held start done count", ndone, 2);
    chk("held start second done edge", cyc - t0, 66);

    // Reset mid-sweep at vector 7 after a mismatch has been counted.
    fault[0][2] = 4'b0001;
    tick; start0 = 1'b1;
    tick; start0 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (vec0 == 4'd7) begin found = 1'b1; break; end
      tick;
    end
    chk("reach vec 7", 32'(found), 1);
    chk("pre-reset mismatch_cnt", 32'(cnt0), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid reset vec_out", 32'(vec0), 0);
    chk("mid reset busy", 32'(busy0), 0);
    chk("mid reset done", 32'(done0), 0);
    chk_res("mid reset", 0, 0, 0, 0, 0, 0);
    ndone = 0;
    repeat (40) begin
      tick;
      if (done0) ndone++;
    end
    chk("no done after reset", ndone, 0);
    fault[0][2] = '0;
    sweep(0, 1'b0, ed);
    chk("post-reset done edge", ed, 32);
    chk_res("post-reset", 0, 0, 0, 0, 0, 1);

    // SETTLE=0 instance, channel 1 wrong at vector 5.
    fault[1][5] = 4'b0010;
    sweep(1, 1'b0, ed);
    chk("t6 done edge", ed, 16);
    chk_res("t6", 1, 1, 5, 1, 'b0010, 0);
    fault[1][5] = '0;

    // Randomised fault tables with stray start pulses during the sweep.
    repeat (16) begin
      d = int'($urandom_range(0, 1));
      for (int v = 0; v < NV; v++)
        fault[d][v] = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0;
      sweep(d, 1'b1, ed);
      chk("rand done edge", ed, NV * (st[d] + 1));
    end
    repeat (3) tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/comb_equiv_sweep.md
# comb_equiv_sweep

Self-running equivalence checker for combinational blocks with WIDTH inputs and one output, implemented NIMPL ways (dataflow, structural, behavioural, primitive, ...). On `start` it sweeps every input vector 0 … 2^WIDTH−1 onto a shared bus and waits SETTLE cycles per vector. It then samples all implementation outputs, compares each against channel 0, and accumulates mismatch statistics. It replaces hand-written exhaustive stimulus lists in the combinational test benches.

## Interface
Parameters:
- WIDTH, default 4: input vector width (1–16).
- NIMPL, default 4: number of implementations compared (2–16). Channel 0 is the reference.
- SETTLE, default 1: extra hold cycles per vector before sampling (0–255).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- vec_out  out  WIDTH  vector driven to every implementation's inputs.
- y_in  in  NIMPL  bit i is the output of implementation i.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  high after `done` when mismatch_cnt==0; cleared by start.
- mismatch_cnt  out  WIDTH+1  number of vectors with any channel ≠ channel 0.
- first_fail_vec  out  WIDTH  vector of the first mismatch.
- fail_valid  out  1  first_fail_vec is meaningful.
- fail_mask  out  NIMPL  sticky; bit i set if channel i ever disagreed with channel 0. Bit 0 is always 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → RUN; vec_out←0, wait_cnt←0, busy←1; mismatch_cnt, fail_mask, fail_valid, first_fail_vec and pass all cleared.
- RUN, wait_cnt<SETTLE: wait_cnt++.
- RUN, wait_cnt==SETTLE: compare y_in. On mismatch (any bit ≠ y_in[0]):
  - mismatch_cnt++;
  - fail_mask |= (y_in ^ {NIMPL{y_in[0]}});
  - if !fail_valid: first_fail_vec←vec_out, fail_valid←1.
  - Then wait_cnt←0.
  - If vec_out==all-ones: → DONE, busy←0, done←1, pass←(final count==0), with the last compare included.
  - Else vec_out++.
- DONE: done←0 → IDLE. Results hold until the next start or rst.
- Vector wrap-around never happens: the sweep ends at all-ones.
- mismatch_cnt is WIDTH+1 bits, so 2^WIDTH fits; no saturation is needed.
- start while in RUN or DONE is ignored; start held high re-triggers only from IDLE.

## Timing
- Reset values: vec_out=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_vec=0, fail_valid=0, fail_mask=0; state IDLE.
- rst has priority over everything, including mid-sweep: the next cycle shows reset values and no done is issued.
- Start edge = edge 0. Vector k is presented from edge k·(SETTLE+1) and sampled at edge (k+1)·(SETTLE+1).
- `done` is high in the cycle after edge 2^WIDTH·(SETTLE+1). Example: WIDTH=4, SETTLE=1 → edge 32.
- y_in must be stable SETTLE+1 cycles after vec_out changes; the DUT path is purely combinational.
- Earliest re-start: start sampled in the cycle after done, i.e. two edges after the final compare.

## Configuration
- COMB_EQUIV_XCHECK_EN defined:
  - Comparison uses the case-inequality operator (!==).
  - Any X/Z on y_in[i] while y_in[0] is known (or the reverse) counts as a mismatch and sets fail_mask[i].
  - Simulation-only build.
- Undefined:
  - Comparison uses logical != and is synthesizable.
  - An X result is treated as no mismatch.

## Test plan
- WIDTH=4, SETTLE=1, all four channels y=^vec → done after edge 32, mismatch_cnt=0, pass=1, fail_mask=4'b0000, fail_valid=0.
- Channel 2 inverted only at vec 4'hA → mismatch_cnt=1, first_fail_vec=4'hA, fail_valid=1, fail_mask=4'b0100, pass=0.
- Channels 1 and 3 inverted at vec 3 and 12 → mismatch_cnt=2, first_fail_vec=4'h3, fail_mask=4'b1010.
- start held high through the whole sweep, plus extra pulses while busy → exactly one done per sweep. The next sweep re-triggers from IDLE with cleared counters.
- rst at vec_out=7 mid-sweep → next cycle all outputs at reset values, done never pulses. A fresh start completes normally.
- SETTLE=0, then channel 1 driven x at vec 5 → done after edge 16 and vec_out changes every cycle. With COMB_EQUIV_XCHECK_EN: mismatch_cnt=1, fail_mask[1]=1. Without it: mismatch_cnt=0.
